// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a single-port data memory (sub-word loads, RMW sub-word stores).
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module lsu_ctrl #(
  parameter int MEM_WIDTH       = 8,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int REG_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [REG_WIDTH-1:0]       req_addr,
  input  logic [REG_WIDTH-1:0]       req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [REG_WIDTH-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       dmem_wr_en,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0]       dmem_wr_data,
  input  logic [REG_WIDTH-1:0]       dmem_rd_data
);

  localparam int LANES = REG_WIDTH / MEM_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                       state_reg;
  logic                         we_reg;
  logic [2:0]                   funct3_reg;
  logic [1:0]                   off_reg;
  logic [2*MEM_WIDTH-1:0]       wdata_reg;
  logic                         req_ready_reg;
  logic                         rsp_valid_reg;
  logic                         rsp_err_reg;
  logic [REG_WIDTH-1:0]         rsp_rdata_reg;
  logic                         wr_en_reg;
  logic [DMEM_ADDR_WIDTH-1:0]   addr_reg;
  logic [REG_WIDTH-1:0]         wr_data_reg;

  logic                         legal_code;
  logic                         misaligned;
  logic                         req_err;
  logic                         unused_addr_bits;

  assign unused_addr_bits = ^req_addr[REG_WIDTH-1:DMEM_ADDR_WIDTH];

  always_comb begin
    legal_code = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal_code = 1'b1;
      3'b100, 3'b101:         legal_code = !req_we;
      default:                legal_code = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign req_err = !legal_code || misaligned;

  // Split the read word into byte lanes and build the RMW merge lane by lane.
  logic [MEM_WIDTH-1:0]   rd_bytes [LANES];
  logic [LANES-1:0]       lane_mask;
  logic [REG_WIDTH-1:0]   store_lanes;
  logic [REG_WIDTH-1:0]   merged_word;
  logic                   sub_byte;

  assign sub_byte    = (funct3_reg[1:0] == 2'b00);
  assign store_lanes = sub_byte ? {LANES{wdata_reg[MEM_WIDTH-1:0]}}
                                : {(LANES/2){wdata_reg}};

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign rd_bytes[gi]  = dmem_rd_data[gi*MEM_WIDTH +: MEM_WIDTH];
      assign lane_mask[gi] = sub_byte ? (int'(off_reg) == gi)
                                      : (int'(off_reg[1]) == gi / 2);
      assign merged_word[gi*MEM_WIDTH +: MEM_WIDTH] =
        lane_mask[gi] ? store_lanes[gi*MEM_WIDTH +: MEM_WIDTH] : rd_bytes[gi];
    end
  endgenerate

  logic [MEM_WIDTH-1:0]   ld_byte;
  logic [2*MEM_WIDTH-1:0] ld_half;
  logic [REG_WIDTH-1:0]   ld_ext;

  assign ld_byte = rd_bytes[off_reg];
  assign ld_half = dmem_rd_data[(off_reg[1] ? 2*MEM_WIDTH : 0) +: 2*MEM_WIDTH];

  always_comb begin
    case (funct3_reg)
      3'b000:  ld_ext = {{(REG_WIDTH-MEM_WIDTH){ld_byte[MEM_WIDTH-1]}}, ld_byte};
      3'b001:  ld_ext = {{(REG_WIDTH-2*MEM_WIDTH){ld_half[2*MEM_WIDTH-1]}}, ld_half};
      3'b100:  ld_ext = {{(REG_WIDTH-MEM_WIDTH){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(REG_WIDTH-2*MEM_WIDTH){1'b0}}, ld_half};
      default: ld_ext = dmem_rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      off_reg       <= 2'b00;
      wdata_reg     <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      wr_en_reg     <= 1'b0;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg        <= req_we;
            funct3_reg    <= req_funct3;
            off_reg       <= req_addr[1:0];
            wdata_reg     <= req_wdata[2*MEM_WIDTH-1:0];
            req_ready_reg <= 1'b0;
            if (req_err) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              addr_reg <= {req_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
              if (req_we && req_funct3 == 3'b010) begin
                state_reg   <= WRITE;
                wr_en_reg   <= 1'b1;
                wr_data_reg <= req_wdata;
              end else begin
                state_reg <= READ;
              end
            end
          end
        end
        READ: begin
          if (we_reg) begin
            state_reg   <= WRITE;
            wr_en_reg   <= 1'b1;
            wr_data_reg <= merged_word;
          end else begin
            state_reg     <= RESP;
            addr_reg      <= '0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= ld_ext;
          end
        end
        WRITE: begin
          state_reg     <= RESP;
          wr_en_reg     <= 1'b0;
          wr_data_reg   <= '0;
          addr_reg      <= '0;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            req_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_err      = rsp_err_reg;
  assign rsp_rdata    = rsp_rdata_reg;
  // Reset during WRITE must keep the memory from committing on that same edge.
  assign dmem_wr_en   = wr_en_reg && !reset;
  assign dmem_addr    = addr_reg;
  assign dmem_wr_data = wr_data_reg;

endmodule
